// File: rtl/pixel_frame_stats.sv
// Per-frame pixel statistics: min, max, sum and count above a threshold that is
// latched at start. Results are published when the frame's last pixel is accepted.
module pixel_frame_stats #(
  parameter int FRAME_PIXELS = 98304,
  parameter int CW           = 17
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [7:0]      threshold,
  input  logic            pix_valid,
  input  logic [7:0]      pix_in,
  output logic            busy,
  output logic            done,
  output logic [7:0]      pix_min,
  output logic [7:0]      pix_max,
  output logic [CW+7:0]   pix_sum,
  output logic [CW-1:0]   above_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_PIXELS - 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_thr;
  logic [7:0]    r_min;
  logic [7:0]    r_max;
  logic [CW+7:0] r_sum;
  logic [CW-1:0] r_above;

  logic          r_busy;
  logic          r_done;
  logic [7:0]    r_pix_min;
  logic [7:0]    r_pix_max;
  logic [CW+7:0] r_pix_sum;
  logic [CW-1:0] r_above_cnt;

  logic          w_accept;
  logic          w_last;
  logic [7:0]    w_min_nxt;
  logic [7:0]    w_max_nxt;
  logic [CW+7:0] w_sum_nxt;
  logic [CW-1:0] w_above_nxt;

  assign w_accept    = (r_state == S_ACCUM) && pix_valid;
  assign w_last      = w_accept && (r_cnt == LAST_IDX);
  assign w_min_nxt   = (pix_in < r_min) ? pix_in : r_min;
  assign w_max_nxt   = (pix_in > r_max) ? pix_in : r_max;
  assign w_sum_nxt   = r_sum + {{CW{1'b0}}, pix_in};
  assign w_above_nxt = r_above + {{(CW-1){1'b0}}, (pix_in > r_thr)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_thr       <= '0;
      r_min       <= '0;
      r_max       <= '0;
      r_sum       <= '0;
      r_above     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pix_min   <= '0;
      r_pix_max   <= '0;
      r_pix_sum   <= '0;
      r_above_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_ACCUM;
            r_busy  <= 1'b1;
            r_thr   <= threshold;
            r_cnt   <= '0;
            r_min   <= 8'hFF;
            r_max   <= 8'h00;
            r_sum   <= '0;
            r_above <= '0;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_cnt   <= r_cnt + 1'b1;
            r_min   <= w_min_nxt;
            r_max   <= w_max_nxt;
            r_sum   <= w_sum_nxt;
            r_above <= w_above_nxt;
          end
          // Publish on the accepting edge so results are valid while done is high.
          if (w_last) begin
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_pix_min   <= w_min_nxt;
            r_pix_max   <= w_max_nxt;
            r_pix_sum   <= w_sum_nxt;
            r_above_cnt <= w_above_nxt;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pix_min   = r_pix_min;
  assign pix_max   = r_pix_max;
  assign pix_sum   = r_pix_sum;
  assign above_cnt = r_above_cnt;

endmodule
